// File: rtl/reflet_muldiv_pkg.sv
// Shared definitions for the reflet multiply/divide peripheral:
// register offsets, CTRL/STAT bit positions and core state encodings.
package reflet_muldiv_pkg;

  localparam int NUM_REGS = 5;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_OPA    = 3'd1;
  localparam logic [2:0] REG_OPB    = 3'd2;
  localparam logic [2:0] REG_RES_LO = 3'd3;
  localparam logic [2:0] REG_RES_HI = 3'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_OP     = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_OP     = 1;
  localparam int STAT_IRQ_EN = 2;
  localparam int STAT_DONE   = 3;
  localparam int STAT_DBZ    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } core_state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

endpackage

// File: rtl/reflet_muldiv_if.sv
// Reflet system-bus slice seen by the muldiv peripheral: CPU drives the
// select/address/write side, the peripheral returns read data and its irq.
interface reflet_muldiv_if #(
  parameter int wordsize       = 16,
  parameter int base_addr_size = 15
);

  logic                      enable;
  logic [base_addr_size-1:0] addr;
  logic [wordsize-1:0]       data_in;
  logic                      write_en;
  logic [wordsize-1:0]       data_out;
  logic                      irq;

  modport master (
    output enable, addr, data_in, write_en,
    input  data_out, irq
  );

  modport slave (
    input  enable, addr, data_in, write_en,
    output data_out, irq
  );

endinterface

// File: rtl/reflet_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per
// cycle; lo/hi carry the final result during the cycle done_pulse is high.
module reflet_muldiv_core
  import reflet_muldiv_pkg::*;
#(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  op_t                 op,
  input  logic [wordsize-1:0] a,
  input  logic [wordsize-1:0] b,
  output logic                busy,
  output logic                done_pulse,
  output logic                dbz,
  output logic [wordsize-1:0] lo,
  output logic [wordsize-1:0] hi
);

  localparam int              CW   = $clog2(wordsize);
  localparam logic [CW-1:0]   LAST = CW'(wordsize - 1);

  core_state_t         state_q;
  op_t                 op_q;
  logic [CW-1:0]       count_q;
  logic [wordsize-1:0] hi_q;
  logic [wordsize-1:0] lo_q;
  logic [wordsize-1:0] b_q;

  logic [wordsize:0]   mul_sum;
  logic [wordsize:0]   div_shift;
  logic [wordsize-1:0] div_diff;
  logic                div_ge;
  logic [wordsize-1:0] hi_nxt;
  logic [wordsize-1:0] lo_nxt;
  logic                accept;
  logic                last;

  // Division by zero never enters RUN; it completes in the load cycle itself.
  assign dbz        = load && (state_q == IDLE) && (op == OP_DIV) && (b == '0);
  assign accept     = load && (state_q == IDLE) && !dbz;
  assign last       = (state_q == RUN) && (count_q == LAST);
  assign busy       = (state_q == RUN);
  assign done_pulse = last || dbz;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[wordsize-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[wordsize-1:0] - b_q;
    if (op_q == OP_MUL) begin
      hi_nxt = mul_sum[wordsize:1];
      lo_nxt = {mul_sum[0], lo_q[wordsize-1:1]};
    end else begin
      hi_nxt = div_ge ? div_diff : div_shift[wordsize-1:0];
      lo_nxt = {lo_q[wordsize-2:0], div_ge};
    end
  end

  assign lo = dbz ? '1 : lo_nxt;
  assign hi = dbz ? a  : hi_nxt;

  // hi_q holds the running partial product / remainder, lo_q the multiplier
  // being consumed or the dividend turning into the quotient.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            op_q    <= op;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= a;
            b_q     <= b;
          end
        end
        RUN: begin
          hi_q    <= hi_nxt;
          lo_q    <= lo_nxt;
          count_q <= count_q + CW'(1);
          if (last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reflet_muldiv_periph.sv
// Memory-mapped muldiv responder: address decode, software-visible registers
// and the read mux; data_out is zero whenever the block is not addressed.
module reflet_muldiv_periph
  import reflet_muldiv_pkg::*;
#(
  parameter int                        wordsize       = 16,
  parameter int                        base_addr_size = 15,
  parameter logic [base_addr_size-1:0] base_addr      = 15'h7F20
) (
  input  logic                 clk,
  input  logic                 reset,
  reflet_muldiv_if.slave       bus
);

  localparam logic [base_addr_size:0] BASE_EXT = {1'b0, base_addr};
  localparam logic [base_addr_size:0] END_EXT  = BASE_EXT + (base_addr_size + 1)'(NUM_REGS);

  logic [base_addr_size:0] addr_ext;
  logic [2:0]              offset;
  logic                    sel;
  logic                    wr;
  logic                    ctrl_wr;
  logic                    start;

  logic [wordsize-1:0] opa;
  logic [wordsize-1:0] opb;
  logic [wordsize-1:0] res_lo;
  logic [wordsize-1:0] res_hi;
  op_t                 op_q;
  logic                irq_en_q;
  logic                done_q;
  logic                dbz_q;

  logic                core_busy;
  logic                core_done;
  logic                core_dbz;
  logic [wordsize-1:0] core_lo;
  logic [wordsize-1:0] core_hi;

  logic [wordsize-1:0] stat;
  logic [wordsize-1:0] rdata;

  // The compare is done one bit wider so a window at the top of the address
  // space cannot wrap.
  assign addr_ext = {1'b0, bus.addr};
  assign sel      = bus.enable && (addr_ext >= BASE_EXT) && (addr_ext < END_EXT);
  assign offset   = 3'(bus.addr - base_addr);
  assign wr       = sel && bus.write_en;
  assign ctrl_wr  = wr && (offset == REG_CTRL) && !core_busy;
  assign start    = ctrl_wr && bus.data_in[CTRL_START];

  reflet_muldiv_core #(
    .wordsize(wordsize)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (start),
    .op        (op_t'(bus.data_in[CTRL_OP])),
    .a         (opa),
    .b         (opb),
    .busy      (core_busy),
    .done_pulse(core_done),
    .dbz       (core_dbz),
    .lo        (core_lo),
    .hi        (core_hi)
  );

  // Completion is applied after the CTRL write so a division by zero started
  // by that same write still leaves done and dbz set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa      <= '0;
      opb      <= '0;
      res_lo   <= '0;
      res_hi   <= '0;
      op_q     <= OP_MUL;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      if (wr && !core_busy) begin
        case (offset)
          REG_OPA: opa <= bus.data_in;
          REG_OPB: opb <= bus.data_in;
          REG_CTRL: begin
            op_q     <= op_t'(bus.data_in[CTRL_OP]);
            irq_en_q <= bus.data_in[CTRL_IRQ_EN];
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
          end
          default: ;
        endcase
      end
      if (core_done) begin
        res_lo <= core_lo;
        res_hi <= core_hi;
        done_q <= 1'b1;
        dbz_q  <= core_dbz;
      end
    end
  end

  always_comb begin
    stat              = '0;
    stat[STAT_BUSY]   = core_busy;
    stat[STAT_OP]     = (op_q == OP_DIV);
    stat[STAT_IRQ_EN] = irq_en_q;
    stat[STAT_DONE]   = done_q;
    stat[STAT_DBZ]    = dbz_q;
    rdata             = '0;
    if (sel) begin
      case (offset)
        REG_CTRL:   rdata = stat;
        REG_OPA:    rdata = opa;
        REG_OPB:    rdata = opb;
        REG_RES_LO: rdata = res_lo;
        REG_RES_HI: rdata = res_hi;
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.data_out = rdata;
  assign bus.irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_reflet_muldiv_periph.sv
// Scoreboard bench for reflet_muldiv_periph: expected results are queued when
// an operation is started and compared when the block reports done.
module tb_reflet_muldiv_periph;

  localparam int          W    = 16;
  localparam logic [14:0] BASE = 15'h7F20;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  reflet_muldiv_if #(.wordsize(W), .base_addr_size(15)) bus ();

  reflet_muldiv_periph #(
    .wordsize(W),
    .base_addr_size(15),
    .base_addr(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic drive_raw(input logic en, input logic [14:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.enable   = en;
    bus.addr     = a;
    bus.data_in  = d;
    bus.write_en = 1'b1;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    bus.enable   = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [W-1:0] d);
    drive_raw(1'b1, BASE + 15'(off), d);
  endtask

  task automatic read_raw(input logic en, input logic [14:0] a, output logic [W-1:0] d);
    bus.enable   = en;
    bus.addr     = a;
    bus.write_en = 1'b0;
    #1;
    d          = bus.data_out;
    bus.enable = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [W-1:0] d);
    read_raw(1'b1, BASE + 15'(off), d);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic irq_en);
    exp_t             e;
    logic [2*W-1:0]   p;
    bus_write(3'd1, a);
    bus_write(3'd2, b);
    if (op && b == '0) begin
      e.lo = '1; e.hi = a; e.dbz = 1'b1;
    end else if (op) begin
      e.lo = a / b; e.hi = a % b; e.dbz = 1'b0;
    end else begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.lo = p[W-1:0]; e.hi = p[2*W-1:W]; e.dbz = 1'b0;
    end
    sb.push_back(e);
    bus_write(3'd0, {{(W-3){1'b0}}, irq_en, op, 1'b1});
  endtask

  task automatic wait_done(output int busy_cycles, output logic [W-1:0] stat);
    bit got;
    got         = 1'b0;
    busy_cycles = 0;
    stat        = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      bus_read(3'd0, stat);
      if (stat[0]) busy_cycles++;
      else if (stat[3]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL done_timeout: done not seen, stat=%h", stat);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    bus.enable = 1'b0; bus.addr = '0; bus.data_in = '0; bus.write_en = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_stat: got %h expected 0000", d); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", bus.irq); end
    start_op(16'h1234, 16'h5678, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    bus_read(3'd0, d);
    checks++; if (d[0] !== 1'b1) begin errors++; $display("[TB] FAIL reset_prebusy: got %b expected 1", d[0]); end
    reset = 1'b0;
    #2;
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mid_stat: got %h expected 0000", d); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_irq: got %b expected 0", bus.irq); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    bus_read(3'd3, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_res_lo: got %h expected 0000", d); end
    bus_read(3'd4, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_res_hi: got %h expected 0000", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_opa: got %h expected 0000", d); end
    read_raw(1'b0, BASE, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 0000", d); end
    repeat (25) @(negedge clk);
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_no_late_done: got %h expected 0000", d); end
  endtask

  task automatic test_mul();
    int nb; logic [W-1:0] stat, lo, hi; exp_t e;
    start_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    wait_done(nb, stat);
    e = sb.pop_front();
    bus_read(3'd3, lo); bus_read(3'd4, hi);
    checks++; if (nb !== 16) begin errors++; $display("[TB] FAIL mul_busy_cycles: got %0d expected 16", nb); end
    checks++; if (lo !== e.lo) begin errors++; $display("[TB] FAIL mul_lo: got %h expected %h", lo, e.lo); end
    checks++; if (hi !== e.hi) begin errors++; $display("[TB] FAIL mul_hi: got %h expected %h", hi, e.hi); end
    checks++; if (stat !== 16'h0008) begin errors++; $display("[TB] FAIL mul_stat: got %h expected 0008", stat); end
  endtask

  task automatic test_div();
    int nb; logic [W-1:0] stat, lo, hi; exp_t e;
    start_op(16'd1000, 16'd7, 1'b1, 1'b0);
    wait_done(nb, stat);
    e = sb.pop_front();
    bus_read(3'd3, lo); bus_read(3'd4, hi);
    checks++; if (nb !== 16) begin errors++; $display("[TB] FAIL div_busy_cycles: got %0d expected 16", nb); end
    checks++; if (lo !== e.lo) begin errors++; $display("[TB] FAIL div_quot: got %0d expected %0d", lo, e.lo); end
    checks++; if (hi !== e.hi) begin errors++; $display("[TB] FAIL div_rem: got %0d expected %0d", hi, e.hi); end
    checks++; if (stat !== 16'h000A) begin errors++; $display("[TB] FAIL div_stat: got %h expected 000a", stat); end
  endtask

  task automatic test_div_by_zero();
    int nb; logic [W-1:0] stat, lo, hi; exp_t e;
    start_op(16'd1234, 16'd0, 1'b1, 1'b0);
    bus_read(3'd0, stat);
    checks++; if (stat !== 16'h001A) begin errors++; $display("[TB] FAIL dbz_stat_now: got %h expected 001a", stat); end
    wait_done(nb, stat);
    e = sb.pop_front();
    bus_read(3'd3, lo); bus_read(3'd4, hi);
    checks++; if (nb !== 0) begin errors++; $display("[TB] FAIL dbz_busy_cycles: got %0d expected 0", nb); end
    checks++; if (lo !== e.lo) begin errors++; $display("[TB] FAIL dbz_lo: got %h expected %h", lo, e.lo); end
    checks++; if (hi !== e.hi) begin errors++; $display("[TB] FAIL dbz_hi: got %0d expected %0d", hi, e.hi); end
  endtask

  task automatic test_busy_protect();
    int nb; int late_busy; int late_clear; logic [W-1:0] stat, lo, d; exp_t e;
    start_op(16'd3, 16'd5, 1'b0, 1'b0);
    bus_write(3'd1, 16'd9);
    bus_write(3'd0, 16'h0001);
    bus_write(3'd0, 16'h0006);
    wait_done(nb, stat);
    e = sb.pop_front();
    bus_read(3'd3, lo);
    bus_read(3'd1, d);
    checks++; if (lo !== e.lo) begin errors++; $display("[TB] FAIL busy_result: got %0d expected %0d", lo, e.lo); end
    checks++; if (d !== 16'd3) begin errors++; $display("[TB] FAIL busy_opa_kept: got %0d expected 3", d); end
    checks++; if (stat !== 16'h0008) begin errors++; $display("[TB] FAIL busy_stat: got %h expected 0008", stat); end
    late_busy = 0; late_clear = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus_read(3'd0, d);
      if (d[0]) late_busy++;
      if (!d[3]) late_clear++;
    end
    checks++; if (late_busy !== 0) begin errors++; $display("[TB] FAIL busy_second_run: got %0d busy cycles expected 0", late_busy); end
    checks++; if (late_clear !== 0) begin errors++; $display("[TB] FAIL busy_done_held: got %0d cleared cycles expected 0", late_clear); end
  endtask

  task automatic test_bus_isolation_irq();
    int nb; logic [W-1:0] stat, lo, hi, d; exp_t e;
    drive_raw(1'b0, BASE + 15'd1, 16'hABCD);
    drive_raw(1'b1, BASE + 15'd5, 16'h5555);
    drive_raw(1'b0, BASE, 16'h0005);
    bus_read(3'd1, d);
    checks++; if (d !== 16'd3) begin errors++; $display("[TB] FAIL iso_opa: got %h expected 0003", d); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0008) begin errors++; $display("[TB] FAIL iso_stat: got %h expected 0008", d); end
    read_raw(1'b1, BASE + 15'd5, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL iso_out_of_range: got %h expected 0000", d); end
    read_raw(1'b0, BASE + 15'd1, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL iso_disabled: got %h expected 0000", d); end
    start_op(16'd200, 16'd300, 1'b0, 1'b1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_while_busy: got %b expected 0", bus.irq); end
    wait_done(nb, stat);
    e = sb.pop_front();
    bus_read(3'd3, lo); bus_read(3'd4, hi);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_rise: got %b expected 1", bus.irq); end
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("[TB] FAIL irq_result: got %h expected %h", {hi, lo}, {e.hi, e.lo}); end
    checks++; if (stat !== 16'h000C) begin errors++; $display("[TB] FAIL irq_stat: got %h expected 000c", stat); end
    bus_write(3'd0, 16'h0004);
    bus_read(3'd0, d);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_drop: got %b expected 0", bus.irq); end
    checks++; if (d !== 16'h0004) begin errors++; $display("[TB] FAIL irq_clear_stat: got %h expected 0004", d); end
  endtask

  task automatic test_back_to_back();
    int nb; logic [W-1:0] a, b, stat, lo, hi, want; logic op, ie, z; exp_t e;
    for (int i = 0; i < 8; i++) begin
      op = i[0];
      ie = i[1];
      a  = W'($urandom);
      b  = (i == 5) ? 16'd0 : (i == 7) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 65535));
      z  = op && (b == 16'd0);
      start_op(a, b, op, ie);
      bus_read(3'd0, stat);
      want = z ? {11'b0, 1'b1, 1'b1, ie, 1'b1, 1'b0} : {11'b0, 1'b0, 1'b0, ie, op, 1'b1};
      checks++; if (stat !== want) begin errors++; $display("[TB] FAIL b2b_start_stat[%0d]: got %h expected %h", i, stat, want); end
      wait_done(nb, stat);
      e = sb.pop_front();
      bus_read(3'd3, lo); bus_read(3'd4, hi);
      checks++; if (nb !== (z ? 0 : 16)) begin errors++; $display("[TB] FAIL b2b_cycles[%0d]: got %0d expected %0d", i, nb, z ? 0 : 16); end
      checks++; if ({hi, lo, stat[4]} !== {e.hi, e.lo, e.dbz}) begin
        errors++;
        $display("[TB] FAIL b2b_result[%0d]: a=%h b=%h op=%b got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                 i, a, b, op, hi, lo, stat[4], e.hi, e.lo, e.dbz);
      end
      checks++; if (bus.irq !== ie) begin errors++; $display("[TB] FAIL b2b_irq[%0d]: got %b expected %b", i, bus.irq, ie); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_busy_protect();
    test_bus_isolation_irq();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
